pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with registered in_ready.
// Define PIPE_SKID_STAGE_PERF_EN to build the saturating stall/bubble counters.
module pipe_skid_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              doAccept;
   logic              doRelease;

   // Handshake outputs depend only on registered state, never on out_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_valid ? main_q : RESET_DATA;
   assign occupancy = state_q;

   assign doAccept  = in_valid && in_ready;
   assign doRelease = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= RESET_DATA;
         skid_q  <= RESET_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (doAccept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (doAccept && doRelease) begin
               main_d = in_data;
            end else if (doAccept) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (doRelease) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // Skid entry moves up so FIFO order is preserved.
            if (doRelease) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
   end

`ifdef PIPE_SKID_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   // Saturating counters; flush deliberately leaves them untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
      if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + 1'b1;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model plus directed vectors.
// Counter expectations follow PIPE_SKID_STAGE_PERF_EN the same way the design does.
module tb_pipe_skid_stage;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [DATA_W-1:0] RST_DATA = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [DATA_W-1:0] modelQ[$];
   int                modelStall  = 0;
   int                modelBubble = 0;
   logic [DATA_W-1:0] emitLog[$];

   pipe_skid_stage #(
      .DATA_W    (DATA_W),
      .RESET_DATA(RST_DATA),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a bounded FIFO of depth two plus saturating event counts.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         modelQ.delete();
         modelStall  = 0;
         modelBubble = 0;
      end else begin
         automatic bit acc = in_valid && (modelQ.size() < 2);
         automatic bit rel = (modelQ.size() > 0) && out_ready;
         if ((modelQ.size() > 0) && !out_ready && modelStall < (1 << CNT_W) - 1)
            modelStall = modelStall + 1;
         if ((modelQ.size() == 0) && out_ready && modelBubble < (1 << CNT_W) - 1)
            modelBubble = modelBubble + 1;
         if (flush) begin
            modelQ.delete();
         end else begin
            if (rel) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(in_data);
         end
      end
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      logic [DATA_W-1:0] expData;
      int expStall, expBubble;
      expData = (modelQ.size() > 0) ? modelQ[0] : RST_DATA;
`ifdef PIPE_SKID_STAGE_PERF_EN
      expStall  = modelStall;
      expBubble = modelBubble;
`else
      expStall  = 0;
      expBubble = 0;
`endif
      checkVal("out_valid", 64'(out_valid), 64'(modelQ.size() > 0));
      checkVal("in_ready", 64'(in_ready), 64'(modelQ.size() < 2));
      checkVal("out_data", 64'(out_data), 64'(expData));
      checkVal("occupancy", 64'(occupancy), 64'(modelQ.size()));
      checkVal("stall_cnt", 64'(stall_cnt), 64'(expStall));
      checkVal("bubble_cnt", 64'(bubble_cnt), 64'(expBubble));
   endtask

   // Single compare process: every falling edge, plus logging of released words.
   always @(negedge clk) begin
      checkOutput();
      if (reset && out_valid && out_ready) emitLog.push_back(out_data);
   end

   // Drive one cycle of inputs, then land 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0;
      #1;
      checkVal("rst_out_valid", 64'(out_valid), 64'd0);
      checkVal("rst_in_ready", 64'(in_ready), 64'd1);
      checkVal("rst_out_data", 64'(out_data), 64'(RST_DATA));
      checkVal("rst_stall", 64'(stall_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic checkLog(input string name, input logic [DATA_W-1:0] exp[$]);
      checkVal({name, "_len"}, 64'(emitLog.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < emitLog.size(); i++)
         checkVal(name, 64'(emitLog[i]), 64'(exp[i]));
   endtask

   initial begin
      logic [DATA_W-1:0] expSeq[$];

      doReset();
      checkVal("rst_occupancy", 64'(occupancy), 64'd0);

      // First transfer latency from EMPTY
      applyStimulus(1'b1, 32'h0000_0013, 1'b1, 1'b0);
      checkVal("lat_valid", 64'(out_valid), 64'd1);
      checkVal("lat_data", 64'(out_data), 64'h13);
      checkVal("lat_occ", 64'(occupancy), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Backpressure and skid ordering
      emitLog.delete();
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      checkVal("full_occ", 64'(occupancy), 64'd2);
      checkVal("full_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
      checkVal("held_occ", 64'(occupancy), 64'd2);
      checkVal("held_data", 64'(out_data), 64'hA);
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      expSeq = '{32'hA, 32'hB, 32'hC};
      checkLog("order", expSeq);

      // Full-throughput streaming
      emitLog.delete();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, DATA_W'(i), 1'b1, 1'b0);
         checkVal("stream_occ", 64'(occupancy), 64'd1);
         checkVal("stream_data", 64'(out_data), 64'(i));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      expSeq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
      checkLog("stream", expSeq);

      // Flush beats a simultaneous accept
      emitLog.delete();
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
      checkVal("flush_occ", 64'(occupancy), 64'd0);
      checkVal("flush_valid", 64'(out_valid), 64'd0);
      checkVal("flush_data", 64'(out_data), 64'(RST_DATA));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkVal("flush_no_emit", 64'(emitLog.size()), 64'd0);

      // Counter saturation survives flush, cleared by reset
      doReset();
      applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
      repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STAGE_PERF_EN
      checkVal("stall_sat", 64'(stall_cnt), 64'd15);
`else
      checkVal("stall_off", 64'(stall_cnt), 64'd0);
`endif
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STAGE_PERF_EN
      checkVal("stall_after_flush", 64'(stall_cnt), 64'd15);
`else
      checkVal("stall_after_flush", 64'(stall_cnt), 64'd0);
`endif
      doReset();
      checkVal("stall_after_reset", 64'(stall_cnt), 64'd0);

      // Asynchronous reset between edges while FULL
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      checkVal("pre_async_occ", 64'(occupancy), 64'd2);
      #1 reset = 1'b0;
      #1;
      checkVal("async_valid", 64'(out_valid), 64'd0);
      checkVal("async_in_ready", 64'(in_ready), 64'd1);
      checkVal("async_occ", 64'(occupancy), 64'd0);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
      checkVal("post_reset_data", 64'(out_data), 64'h77);
      checkVal("post_reset_occ", 64'(occupancy), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
